// File: rtl/reset_seq_if.sv
// Reset sequencer bundle: reset requests in, staged resets and status out.
//   src_n   : asynchronous active-low reset requests, one bit per source
//   src_en  : per-source enable, 0 masks the source
//   sw_res  : synchronous active-high reset request
//   res_out : active-high reset per stage, stage 0 released first
//   busy    : high while the sequencer is not in RUN
//   cause   : sticky record of the last re-reset {sw_res, sources}
interface reset_seq_if #(
  parameter int unsigned NUM_SRC    = 2,
  parameter int unsigned NUM_STAGES = 2
);
  logic [NUM_SRC-1:0]    src_n;
  logic [NUM_SRC-1:0]    src_en;
  logic                  sw_res;
  logic [NUM_STAGES-1:0] res_out;
  logic                  busy;
  logic [NUM_SRC:0]      cause;

  modport master (
    output src_n, src_en, sw_res,
    input  res_out, busy, cause
  );

  modport slave (
    input  src_n, src_en, sw_res,
    output res_out, busy, cause
  );
endinterface

// File: rtl/reset_seq.sv
// Reset sequencer: synchronizes and debounces asynchronous reset sources, holds all
// reset stages asserted until HOLD_CYCLES request-free cycles have passed, then releases
// the stages one by one, STAGE_GAP cycles apart.
//   clock_160 : sole clock
//   nres      : synchronous active-low reset
//   bus       : reset_seq_if slave (src_n, src_en, sw_res in; res_out, busy, cause out)
module reset_seq #(
  parameter int unsigned NUM_SRC         = 2,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned HOLD_CYCLES     = 1600000,
  parameter int unsigned CNT_W           = 24,
  parameter int unsigned NUM_STAGES      = 2,
  parameter int unsigned STAGE_GAP       = 16
) (
  input logic         clock_160,
  input logic         nres,
  reset_seq_if.slave  bus
);

  localparam int unsigned DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned GW = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;
  localparam int unsigned SW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  typedef enum logic [1:0] {StHold, StRelease, StRun} state_e;

  logic [NUM_SRC-1:0][SYNC_STAGES-1:0] sync_q;
  logic [NUM_SRC-1:0]                  src_act_q, src_act_d;
  logic [NUM_SRC-1:0][DW-1:0]          dcnt_q, dcnt_d;
  state_e                              state_q, state_d;
  logic [CNT_W-1:0]                    hcnt_q, hcnt_d;
  logic [GW-1:0]                       gcnt_q, gcnt_d;
  logic [SW-1:0]                       stg_q, stg_d;
  logic [NUM_STAGES-1:0]               res_q, res_d;
  logic [NUM_SRC:0]                    cause_q, cause_d;
  logic                                req;

  // Debounce: flip src_act only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_comb begin
    src_act_d = src_act_q;
    dcnt_d    = dcnt_q;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      if (!sync_q[i][SYNC_STAGES-1] != src_act_q[i]) begin
        if (dcnt_q[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
          src_act_d[i] = ~src_act_q[i];
          dcnt_d[i]    = '0;
        end else begin
          dcnt_d[i] = dcnt_q[i] + DW'(1);
        end
      end else begin
        dcnt_d[i] = '0;
      end
    end
  end

  // src_en is applied after debouncing so toggling it never restarts a debounce.
  assign req = (|(src_act_q & bus.src_en)) | bus.sw_res;

  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    gcnt_d  = gcnt_q;
    stg_d   = stg_q;
    res_d   = res_q;
    cause_d = cause_q;
    unique case (state_q)
      StHold: begin
        res_d = '1;
        if (req) begin
          hcnt_d = '0;
        end else if (hcnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
          hcnt_d   = '0;
          gcnt_d   = '0;
          res_d[0] = 1'b0;
          if (NUM_STAGES == 1) begin
            state_d = StRun;
            stg_d   = '0;
          end else begin
            state_d = StRelease;
            stg_d   = SW'(1);
          end
        end else begin
          hcnt_d = hcnt_q + CNT_W'(1);
        end
      end
      StRelease: begin
        if (req) begin
          state_d = StHold;
          res_d   = '1;
          hcnt_d  = '0;
          gcnt_d  = '0;
          stg_d   = '0;
          cause_d = {bus.sw_res, src_act_q & bus.src_en};
        end else if (gcnt_q == GW'(STAGE_GAP - 1)) begin
          // stg_q names the next stage to drop
          res_d[stg_q] = 1'b0;
          gcnt_d       = '0;
          stg_d        = stg_q + SW'(1);
          if (stg_q == SW'(NUM_STAGES - 1)) begin
            state_d = StRun;
          end
        end else begin
          gcnt_d = gcnt_q + GW'(1);
        end
      end
      StRun: begin
        if (req) begin
          state_d = StHold;
          res_d   = '1;
          hcnt_d  = '0;
          gcnt_d  = '0;
          stg_d   = '0;
          cause_d = {bus.sw_res, src_act_q & bus.src_en};
        end
      end
      default: begin
        state_d = StHold;
        res_d   = '1;
        hcnt_d  = '0;
        gcnt_d  = '0;
        stg_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock_160) begin
    if (!nres) begin
      sync_q    <= '1;
      src_act_q <= '0;
      dcnt_q    <= '0;
      state_q   <= StHold;
      hcnt_q    <= '0;
      gcnt_q    <= '0;
      stg_q     <= '0;
      res_q     <= '1;
      cause_q   <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_SRC); i++) begin
        sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], bus.src_n[i]};
      end
      src_act_q <= src_act_d;
      dcnt_q    <= dcnt_d;
      state_q   <= state_d;
      hcnt_q    <= hcnt_d;
      gcnt_q    <= gcnt_d;
      stg_q     <= stg_d;
      res_q     <= res_d;
      cause_q   <= cause_d;
    end
  end

  assign bus.res_out = res_q;
  assign bus.busy    = (state_q != StRun);
  assign bus.cause   = cause_q;

endmodule

// File: tb/tb_reset_seq.sv
// Self-checking bench for reset_seq: directed scenarios followed by randomized stimulus,
// every cycle compared against a behavioural model of the release timing.
module tb_reset_seq;
  localparam int unsigned NUM_SRC = 2;
  localparam int unsigned SYNC    = 2;
  localparam int unsigned DEB     = 4;
  localparam int unsigned HOLD    = 8;
  localparam int unsigned CNT_W   = 24;
  localparam int unsigned NS      = 2;
  localparam int unsigned GAP     = 3;
  localparam int          DONE    = (NS - 1) * GAP;

  logic clk  = 1'b0;
  logic nres = 1'b0;

  reset_seq_if #(.NUM_SRC(NUM_SRC), .NUM_STAGES(NS)) bus ();

  reset_seq #(
    .NUM_SRC(NUM_SRC),
    .SYNC_STAGES(SYNC),
    .DEBOUNCE_CYCLES(DEB),
    .HOLD_CYCLES(HOLD),
    .CNT_W(CNT_W),
    .NUM_STAGES(NS),
    .STAGE_GAP(GAP)
  ) dut (
    .clock_160(clk),
    .nres(nres),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: delay line for synchronization, run lengths for debounce,
  // and the release expressed as "cycles since stage 0 dropped".
  logic [NUM_SRC-1:0] m_hist [SYNC];
  logic [NUM_SRC-1:0] m_act;
  int                 m_run [NUM_SRC];
  int                 m_quiet;
  bit                 m_rel;
  int                 m_relt;
  logic [NUM_SRC:0]   m_cause;

  task automatic model_reset();
    for (int j = 0; j < int'(SYNC); j++) m_hist[j] = '1;
    m_act = '0;
    for (int i = 0; i < int'(NUM_SRC); i++) m_run[i] = 0;
    m_quiet = 0;
    m_rel   = 1'b0;
    m_relt  = 0;
    m_cause = '0;
  endtask

  task automatic model_step();
    bit r;
    if (!nres) begin
      model_reset();
      return;
    end
    r = (|(m_act & bus.src_en)) | bus.sw_res;
    if (!m_rel) begin
      if (r) m_quiet = 0;
      else begin
        m_quiet++;
        if (m_quiet == int'(HOLD)) begin
          m_rel  = 1'b1;
          m_relt = 0;
        end
      end
    end else if (r) begin
      m_rel   = 1'b0;
      m_quiet = 0;
      m_cause = {bus.sw_res, m_act & bus.src_en};
    end else if (m_relt < DONE) begin
      m_relt++;
    end
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      if ((!m_hist[SYNC-1][i]) != m_act[i]) begin
        m_run[i]++;
        if (m_run[i] == int'(DEB)) begin
          m_act[i] = ~m_act[i];
          m_run[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    for (int j = int'(SYNC) - 1; j > 0; j--) m_hist[j] = m_hist[j-1];
    m_hist[0] = bus.src_n;
  endtask

  function automatic logic [NS-1:0] exp_res();
    logic [NS-1:0] v;
    for (int k = 0; k < int'(NS); k++) v[k] = !m_rel || (m_relt < k * int'(GAP));
    return v;
  endfunction

  // One clock edge: advance the model, then compare outputs 1 time unit later.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("res_out", 32'(bus.res_out), 32'(exp_res()));
    check("busy", 32'(bus.busy), 32'(!m_rel || (m_relt < DONE)));
    check("cause", 32'(bus.cause), 32'(m_cause));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  int seg;
  int hold_n;

  initial begin
    model_reset();
    bus.src_n  = '1;
    bus.src_en = '1;
    bus.sw_res = 1'b0;

    // Power-up
    ticks(2);
    check("rst_res", 32'(bus.res_out), 32'h3);
    check("rst_busy", 32'(bus.busy), 32'h1);
    check("rst_cause", 32'(bus.cause), 32'h0);
    nres = 1'b1;
    ticks(7);
    check("pwr_e7", 32'(bus.res_out), 32'h3);
    tick();
    check("pwr_e8", 32'(bus.res_out), 32'h2);
    ticks(2);
    check("pwr_e10", 32'(bus.res_out), 32'h2);
    tick();
    check("pwr_e11", 32'(bus.res_out), 32'h0);
    check("pwr_busy", 32'(bus.busy), 32'h0);

    // Short glitch is filtered, a held source re-resets
    bus.src_n = 2'b10;
    ticks(3);
    bus.src_n = 2'b11;
    ticks(10);
    check("glitch", 32'(bus.res_out), 32'h0);
    bus.src_n = 2'b10;
    ticks(6);
    check("held_e6", 32'(bus.res_out), 32'h0);
    tick();
    check("held_e7", 32'(bus.res_out), 32'h3);
    check("held_cause", 32'(bus.cause), 32'h1);
    ticks(3);
    bus.src_n = 2'b11;
    ticks(30);
    check("held_run", 32'(bus.res_out), 32'h0);

    // Masking, then unmasking takes effect on the next edge
    bus.src_en = 2'b10;
    bus.src_n  = 2'b10;
    ticks(20);
    check("masked", 32'(bus.res_out), 32'h0);
    bus.src_en = 2'b11;
    tick();
    check("unmask", 32'(bus.res_out), 32'h3);
    bus.src_n = 2'b11;
    ticks(30);

    // sw_res between stage releases
    bus.sw_res = 1'b1;
    tick();
    bus.sw_res = 1'b0;
    ticks(8);
    check("sw_mid", 32'(bus.res_out), 32'h2);
    bus.sw_res = 1'b1;
    tick();
    bus.sw_res = 1'b0;
    check("sw_res", 32'(bus.res_out), 32'h3);
    check("sw_cause", 32'(bus.cause), 32'h4);
    ticks(8);
    check("sw_e8", 32'(bus.res_out), 32'h2);
    ticks(3);
    check("sw_e11", 32'(bus.res_out), 32'h0);

    // nres during RELEASE
    bus.sw_res = 1'b1;
    tick();
    bus.sw_res = 1'b0;
    ticks(8);
    nres = 1'b0;
    tick();
    nres = 1'b1;
    check("nres_res", 32'(bus.res_out), 32'h3);
    check("nres_cause", 32'(bus.cause), 32'h0);
    ticks(7);
    check("nres_e7", 32'(bus.res_out), 32'h3);
    tick();
    check("nres_e8", 32'(bus.res_out), 32'h2);

    // Randomized segments: idle stretches, bounces, mask changes, sw_res and nres pulses
    for (int s = 0; s < 150; s++) begin
      hold_n = 0;
      if ($urandom_range(0, 3) == 0) bus.src_en = 2'($urandom_range(0, 3));
      seg = $urandom_range(0, 9);
      if (seg < 4) begin
        bus.src_n = 2'b11;
        hold_n    = $urandom_range(10, 30);
      end else begin
        bus.src_n = 2'($urandom_range(0, 3));
        hold_n    = $urandom_range(1, 8);
      end
      for (int c = 0; c < hold_n; c++) begin
        bus.sw_res = ($urandom_range(0, 63) == 0);
        nres       = ($urandom_range(0, 199) != 0);
        tick();
      end
      bus.sw_res = 1'b0;
      nres       = 1'b1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reset_seq.md
RESET_SEQ -- requirements
Module: reset_seq

Interface
REQ-001 SHALL provide parameter NUM_SRC, default 2: number of asynchronous reset sources.
REQ-002 SHALL provide parameter SYNC_STAGES, default 2: synchronizer flops per source, minimum 2.
REQ-003 SHALL provide parameter DEBOUNCE_CYCLES, default 16: consecutive stable samples needed to change a debounced source, minimum 1.
REQ-004 SHALL provide parameter HOLD_CYCLES, default 1600000: consecutive request-free cycles before release begins, minimum 1.
REQ-005 SHALL provide parameter CNT_W, default 24: hold counter width; HOLD_CYCLES SHALL be at most 2^CNT_W.
REQ-006 SHALL provide parameter NUM_STAGES, default 2: number of staged reset outputs.
REQ-007 SHALL provide parameter STAGE_GAP, default 16: cycles between successive stage deassertions, minimum 1.
REQ-008 clock_160  input  1  sole clock; all state changes on its rising edge.
REQ-009 nres  input  1  reset; synchronous and active-low.
REQ-010 src_n  input  NUM_SRC  asynchronous active-low reset requests, for example board button and serial RTS.
REQ-011 src_en  input  NUM_SRC  per-source enable; 0 masks that source.
REQ-012 sw_res  input  1  synchronous active-high reset request, for example a core reboot bit.
REQ-013 res_out  output  NUM_STAGES  active-high reset per stage; stage 0 is released first.
REQ-014 busy  output  1  high whenever the state is not RUN.
REQ-015 cause  output  NUM_SRC+1  sticky record of the last re-reset: bit NUM_SRC is sw_res, bits below are sources.

Function
REQ-016 Each src_n bit SHALL pass through a SYNC_STAGES-flop synchronizer before any other use.
REQ-017 Each source SHALL have a debounced flag src_act[i]; it changes only after the synchronized value (inverted) has differed from src_act[i] for DEBOUNCE_CYCLES consecutive cycles; its counter clears on any sample equal to src_act[i].
REQ-018 req SHALL be (|(src_act & src_en)) | sw_res, evaluated every cycle.
REQ-019 The FSM SHALL have three states, HOLD, RELEASE and RUN, with a hold counter hcnt of CNT_W bits and a stage counter.
REQ-020 In HOLD: all res_out bits are 1; req=1 clears hcnt; req=0 increments hcnt; at an edge where hcnt==HOLD_CYCLES-1 and req=0, the FSM enters RELEASE and res_out[0] clears on that same edge.
REQ-021 In RELEASE: res_out[k] clears k*STAGE_GAP edges after res_out[0] clears; the edge that clears res_out[NUM_STAGES-1] also enters RUN. With NUM_STAGES=1, the FSM enters RUN directly from HOLD.
REQ-022 In RELEASE or RUN, req=1 SHALL enter HOLD, set all res_out to 1 and clear hcnt on the next edge; req SHALL take priority over any simultaneous stage release.
REQ-023 On every entry to HOLD from RELEASE or RUN, cause SHALL load {sw_res, src_act & src_en}; cause is otherwise unchanged.
REQ-024 Worst-case latency from src_n falling (enabled, held) to res_out all 1 SHALL be SYNC_STAGES+DEBOUNCE_CYCLES+1 edges; from sw_res it SHALL be 1 edge.
REQ-025 Changing src_en SHALL take effect on req in the same cycle, with no debounce restart.

Reset
REQ-026 While nres=0 at an edge: state HOLD, hcnt=0, stage counter 0, res_out all 1, busy=1, cause=0, src_act all 0, debounce counters 0, synchronizer flops 1.
REQ-027 nres=0 mid-RELEASE or mid-RUN SHALL abandon the sequence immediately; release restarts from hcnt=0 after nres returns high.

Verification (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, HOLD_CYCLES=8, NUM_STAGES=2, STAGE_GAP=3, NUM_SRC=2)
REQ-028 Power-up: nres=0 for 2 edges, then 1, src_n=11, sw_res=0 -> res_out[0] falls at edge 8 after nres high, res_out[1] and busy fall at edge 11, cause=000.
REQ-029 Glitch: in RUN, src_n[0]=0 for 3 cycles -> res_out stays 00; held 10 cycles -> res_out=11 within 7 edges, cause=001, release restarts 8 edges after the source clears.
REQ-030 Masking: src_en=10, src_n[0] held low 20 cycles -> res_out stays 00; then src_en=11 -> res_out=11 next edge.
REQ-031 sw_res pulse 1 cycle between res_out[0] falling and res_out[1] falling -> res_out=11 next edge, cause=100, full 8+3 sequence repeats.
REQ-032 nres=0 one cycle during RELEASE -> res_out=11, cause=000, res_out[0] falls 8 edges after nres returns high.
REQ-033 Hold restart: src_n[1] bounces so that src_act[1] is 1 at hcnt=5 -> hcnt clears; release occurs 8 request-free edges later.
